bcd_serial_addsub: RTL
======================

// Module: bcd_serial_addsub
// PURPOSE
//   Digit-serial, sequential BCD add/subtract unit for DIGITS-digit words. It handles one BCD
//   digit per clock, so only one digit adder is needed regardless of width. Subtraction returns
//   a sign-magnitude result; addition returns the sum plus a carry-out.
//   Sits between the operand registers and the display/accumulator path. Takes over from the
//   fixed 8-digit combinational word adder/subtractor.
// PARAMETERS
//   DIGITS   8   number of BCD digits per operand/result (>=1); index counter is $clog2(DIGITS)+1 bits
// PORTS
//   clk      in   1          single clock, rising edge
//   reset    in   1          synchronous, active-high
//   start    in   1          request; accepted only when busy==0
//   op       in   1          0 = A+B, 1 = A-B; sampled with start
//   a        in   4*DIGITS   operand A, digit 0 = bits [3:0]; sampled with start
//   b        in   4*DIGITS   operand B; sampled with start
//   busy     out  1          high from the cycle after acceptance through the DONE cycle
//   done     out  1          one-cycle pulse: result/flags valid
//   result   out  4*DIGITS   BCD magnitude; held until the next accepted start
//   neg      out  1          op=1 only: result is negative (A<B)
//   carry    out  1          op=0 only: decimal overflow (sum >= 10^DIGITS)
//   err      out  1          an operand nibble was >9; result forced to 0
// BEHAVIOUR
//   - Reset: state IDLE; busy, done, neg, carry and err = 0; result = 0; digit index = 0.
//     Reset wins over any other event, including mid-operation. No done is produced for the
//     aborted job.
//   - Accept: start && state==IDLE. Capture a, b and op into internal regs. Clear neg, carry
//     and err. Go to CHECK. start in any other state is ignored, with no queueing.
//   - CHECK (1 cycle): if any nibble of A or B is >9: err=1, result=0, go to DONE.
//     Otherwise: idx=0, c = op (carry-in 1 for 10's-complement subtract), go to CALC.
//   - Digit step: bd = op ? 9-B[idx] : B[idx]; s = A[idx] + bd + c (5 bits).
//     If s>9: digit = s+6 (low 4 bits), c=1. Otherwise: digit = s, c=0.
//     Write the digit to result[idx]; idx++.
//   - CALC (DIGITS cycles): one digit step per cycle. After the last digit:
//       op=0: carry=c, go to DONE.
//       op=1, c=1: A>=B, neg=0, result valid, go to DONE (A==B gives +0).
//       op=1, c=0: A<B, neg=1; idx=0, c=1, go to NEGATE.
//   - NEGATE (DIGITS cycles): 10's complement of result in place, one digit per cycle:
//     digit = (9-result[idx]) + c, with the same >9 correction.
//     After the last digit, go to DONE.
//   - DONE (1 cycle): done=1, busy=1, then go to IDLE (busy=0).
//     Outputs hold until the next accepted start.
//   - Latency, counting the acceptance edge as cycle 0; done is high in cycle L:
//       err: L=2
//       add, or subtract with A>=B: L=DIGITS+2
//       subtract with A<B: L=2*DIGITS+2
//   - start asserted in the same cycle done is high is ignored (state is still DONE).
//     The earliest accept is the following cycle.
//   - result shows partial digits while busy. Consumers must qualify it with done/!busy.
// STRUCTURE
//   - Package bcd_pkg: BCD_W=4, BCD_MAX=4'd9, BCD_ADJ=4'd6, OP_ADD/OP_SUB, and the state
//     encoding (IDLE, CHECK, CALC, NEGATE, DONE, 3-bit).
//   - Sub-module bcd_digit_step: combinational (a[3:0], b[3:0], inv_b, cin) -> (s[3:0], cout),
//     with inv_b applying the 9's complement.
//   - One instance serves both CALC and NEGATE: in NEGATE it is fed a=0, b=result[idx], inv_b=1.
//   - Top level holds the FSM, the digit index, the operand/result shift-free indexed registers
//     and the flags.
// TESTING (DIGITS=8)
//   1. Add: a=00000123, b=00000989, op=0 -> done at cycle 10, result=00001112, carry=0, neg=0.
//   2. Add overflow: a=99999999, b=00000001 -> result=00000000, carry=1, done at cycle 10.
//   3. Sub positive: a=00005000, b=00001234, op=1 -> result=00003766, neg=0, done at cycle 10.
//      Also a==b=00004321 -> result=0, neg=0.
//   4. Sub negative: a=00000012, b=00000100, op=1 -> result=00000088, neg=1, done at cycle 18.
//   5. Invalid: a=0000A000, b=0 -> err=1, result=0, done at cycle 2.
//      A start pulsed while busy is ignored. Back-to-back jobs, with start in the cycle after
//      done, both complete correctly.
//   6. Reset in cycle 5 of a subtract -> next cycle all outputs 0, state IDLE, no done pulse.
//      A new job then completes normally.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared definitions for the digit-serial BCD add/subtract unit.
// Contents: digit width and decimal constants, operation encoding,
// FSM state encoding, and a digit validity helper.
package bcd_pkg;

   localparam int         BCD_W   = 4;
   localparam logic [3:0] BCD_MAX = 4'd9;
   localparam logic [3:0] BCD_ADJ = 4'd6;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CHECK  = 3'd1,
      ST_CALC   = 3'd2,
      ST_NEGATE = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   // True when the nibble is a legal BCD digit (0..9).
   function automatic logic bcd_digit_valid(input logic [3:0] d);
      return (d <= BCD_MAX);
   endfunction

endpackage

// File: rtl/bcd_digit_step.sv
// One BCD digit adder with decimal correction.
// Ports:
//   a, b   : input BCD digits
//   inv_b  : replace b by its 9's complement (9-b) before adding
//   cin    : decimal carry in
//   s      : corrected BCD sum digit
//   cout   : decimal carry out
module bcd_digit_step
   import bcd_pkg::*;
(
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       inv_b,
   input  logic       cin,
   output logic [3:0] s,
   output logic       cout
);

   logic [3:0] bd_s;
   logic [4:0] sum_s;
   logic [4:0] adj_s;

   // Binary digit sum, then +6 correction when the sum leaves the decimal range.
   always_comb begin
      bd_s  = inv_b ? (BCD_MAX - b) : b;
      sum_s = {1'b0, a} + {1'b0, bd_s} + {4'b0000, cin};
      adj_s = sum_s + {1'b0, BCD_ADJ};
      if (sum_s > {1'b0, BCD_MAX}) begin
         s    = adj_s[3:0];
         cout = 1'b1;
      end else begin
         s    = sum_s[3:0];
         cout = 1'b0;
      end
   end

endmodule

// File: rtl/bcd_serial_addsub.sv
// Digit-serial BCD add/subtract unit, one digit per clock.
// Subtraction yields sign-magnitude (neg + magnitude); addition yields sum + carry.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   start, op  : request (accepted only when idle), 0 = A+B, 1 = A-B
//   a, b       : BCD operands, digit 0 in bits [3:0]
//   busy, done : job in flight / one-cycle completion pulse
//   result     : BCD magnitude, valid with done, held until next accepted start
//   neg, carry : A<B for subtract / decimal overflow for add
//   err        : an operand nibble was not BCD; result forced to 0
module bcd_serial_addsub
   import bcd_pkg::*;
#(
   parameter int DIGITS = 8
)
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  op,
   input  logic [4*DIGITS-1:0]   a,
   input  logic [4*DIGITS-1:0]   b,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   result,
   output logic                  neg,
   output logic                  carry,
   output logic                  err
);

   localparam int W  = BCD_W * DIGITS;
   localparam int IW = $clog2(DIGITS) + 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

   state_t          state_r, state_nx_s;
   logic [IW-1:0]   idx_r;
   logic            c_r;
   logic            op_r;
   logic [W-1:0]    a_r, b_r, result_r;
   logic            busy_r, done_r, neg_r, carry_r, err_r;

   logic [3:0]      a_dig_s, b_dig_s, r_dig_s;
   logic [3:0]      step_a_s, step_b_s, step_s;
   logic            step_inv_s, step_cout_s;
   logic [W-1:0]    result_wr_s;
   logic            invalid_s;
   logic            last_s;

   // True when any nibble of the word is not a legal BCD digit.
   function automatic logic any_invalid(input logic [W-1:0] w);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         bad = bad | ~bcd_digit_valid(w[i*BCD_W +: BCD_W]);
      end
      return bad;
   endfunction

   // Select the current digit of each stored word and build the result with that digit replaced.
   always_comb begin
      a_dig_s     = 4'd0;
      b_dig_s     = 4'd0;
      r_dig_s     = 4'd0;
      result_wr_s = result_r;
      for (int i = 0; i < DIGITS; i++) begin
         a_dig_s = a_dig_s | (a_r[i*BCD_W +: BCD_W]      & {BCD_W{idx_r == IW'(i)}});
         b_dig_s = b_dig_s | (b_r[i*BCD_W +: BCD_W]      & {BCD_W{idx_r == IW'(i)}});
         r_dig_s = r_dig_s | (result_r[i*BCD_W +: BCD_W] & {BCD_W{idx_r == IW'(i)}});
         result_wr_s[i*BCD_W +: BCD_W] = (idx_r == IW'(i)) ? step_s : result_r[i*BCD_W +: BCD_W];
      end
   end

   // Shared digit adder: NEGATE computes 0 + (9 - result) + c, CALC computes A +/- B.
   always_comb begin
      step_a_s   = (state_r == ST_NEGATE) ? 4'd0 : a_dig_s;
      step_b_s   = (state_r == ST_NEGATE) ? r_dig_s : b_dig_s;
      step_inv_s = (state_r == ST_NEGATE) ? 1'b1 : op_r;
      invalid_s  = any_invalid(a_r) | any_invalid(b_r);
      last_s     = (idx_r == LAST_IDX);
   end

   bcd_digit_step u_step (
      .a     (step_a_s),
      .b     (step_b_s),
      .inv_b (step_inv_s),
      .cin   (c_r),
      .s     (step_s),
      .cout  (step_cout_s)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next-state logic; a subtract that ends without carry still needs the magnitude negated.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_nx_s = ST_CHECK;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_CHECK: begin
            if (invalid_s) begin
               state_nx_s = ST_DONE;
            end else begin
               state_nx_s = ST_CALC;
            end
         end
         ST_CALC: begin
            if (!last_s) begin
               state_nx_s = ST_CALC;
            end else if ((op_r == OP_SUB) && !step_cout_s) begin
               state_nx_s = ST_NEGATE;
            end else begin
               state_nx_s = ST_DONE;
            end
         end
         ST_NEGATE: begin
            if (last_s) begin
               state_nx_s = ST_DONE;
            end else begin
               state_nx_s = ST_NEGATE;
            end
         end
         ST_DONE: begin
            state_nx_s = ST_IDLE;
         end
         default: begin
            state_nx_s = ST_IDLE;
         end
      endcase
   end

   // Operand capture, digit index, running carry, result digits and flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         a_r      <= '0;
         b_r      <= '0;
         op_r     <= 1'b0;
         idx_r    <= '0;
         c_r      <= 1'b0;
         result_r <= '0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         neg_r    <= 1'b0;
         carry_r  <= 1'b0;
         err_r    <= 1'b0;
      end else begin
         busy_r <= (state_nx_s != ST_IDLE);
         done_r <= (state_nx_s == ST_DONE);
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  a_r     <= a;
                  b_r     <= b;
                  op_r    <= op;
                  neg_r   <= 1'b0;
                  carry_r <= 1'b0;
                  err_r   <= 1'b0;
               end
            end
            ST_CHECK: begin
               if (invalid_s) begin
                  err_r    <= 1'b1;
                  result_r <= '0;
               end else begin
                  idx_r <= '0;
                  c_r   <= op_r;   // carry-in 1 turns 9's complement into 10's complement
               end
            end
            ST_CALC: begin
               result_r <= result_wr_s;
               c_r      <= step_cout_s;
               if (last_s) begin
                  idx_r <= '0;
                  if (op_r == OP_ADD) begin
                     carry_r <= step_cout_s;
                  end else if (!step_cout_s) begin
                     neg_r <= 1'b1;
                     c_r   <= 1'b1;
                  end
               end else begin
                  idx_r <= idx_r + IW'(1);
               end
            end
            ST_NEGATE: begin
               result_r <= result_wr_s;
               c_r      <= step_cout_s;
               if (last_s) begin
                  idx_r <= '0;
               end else begin
                  idx_r <= idx_r + IW'(1);
               end
            end
            ST_DONE: begin
               idx_r <= '0;
            end
            default: begin
               idx_r <= '0;
            end
         endcase
      end
   end

   assign busy   = busy_r;
   assign done   = done_r;
   assign result = result_r;
   assign neg    = neg_r;
   assign carry  = carry_r;
   assign err    = err_r;

endmodule
